// File: rtl/dmem_if.sv
// Load/store bus between the core's memory stage and the multi-cycle data RAM responder.
// The master drives req_*; the slave (the responder) drives ready, response and busy.
interface dmem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data RAM slave: one request per handshake, WAIT_CYCLES wait states,
// byte/half/word stores with lane enables and sign/zero-extended loads.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic     clk,
  input  logic     reset,
  dmem_if.slave    bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // WAIT spans WAIT_CYCLES+1 cycles, so the response lands WAIT_CYCLES+1 edges after accept.
  localparam logic [4:0] WAIT_LOAD = 5'(WAIT_CYCLES + 1);

  logic [1:0]            state;
  logic [4:0]            wait_cnt;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [2:0]            lat_funct3;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  enter_resp;
  logic                  store_commit;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  illegal;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;
  logic [3:0]            byte_en;
  logic [DATA_WIDTH-1:0] st_word;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] ld_data;

  assign word_addr    = {2'b00, lat_addr[ADDR_WIDTH-1:2]};
  assign word_idx     = lat_addr[IDX_W+1:2];
  assign mem_rd       = mem[word_idx];
  assign enter_resp   = (state == ST_WAIT) && (wait_cnt == 5'd1);
  assign store_commit = !reset && enter_resp && lat_we && !req_err;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    illegal      = 1'b0;
    misaligned   = 1'b0;
    byte_en      = 4'b0000;
    st_word      = '0;
    ld_data      = '0;
    out_of_range = (word_addr >= ADDR_WIDTH'(DEPTH_WORDS));
    lane         = mem_rd >> {lat_addr[1:0], 3'b000};

    case (lat_funct3)
      F3_B, F3_BU: begin
        byte_en = 4'b0001 << lat_addr[1:0];
        st_word = {4{lat_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        misaligned = lat_addr[0];
        byte_en    = lat_addr[1] ? 4'b1100 : 4'b0011;
        st_word    = {2{lat_wdata[15:0]}};
      end
      F3_W: begin
        misaligned = |lat_addr[1:0];
        byte_en    = 4'b1111;
        st_word    = lat_wdata;
      end
      default: illegal = 1'b1;
    endcase

    // Unsigned variants only make sense for loads.
    if (lat_we && (lat_funct3 == F3_BU || lat_funct3 == F3_HU)) illegal = 1'b1;

    req_err = illegal || misaligned || out_of_range;

    case (lat_funct3)
      F3_B:    ld_data = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      F3_H:    ld_data = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      F3_W:    ld_data = lane;
      F3_BU:   ld_data = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      F3_HU:   ld_data = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_funct3  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            lat_we     <= bus.req_we;
            lat_addr   <= bus.req_addr;
            lat_wdata  <= bus.req_wdata;
            lat_funct3 <= bus.req_funct3;
            wait_cnt   <= WAIT_LOAD;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 5'd1) begin
            wait_cnt    <= '0;
            state       <= ST_RESP;
            rsp_err_q   <= req_err;
            rsp_rdata_q <= (req_err || lat_we) ? '0 : ld_data;
          end else begin
            wait_cnt <= wait_cnt - 5'd1;
          end
        end
        ST_RESP: begin
          state       <= ST_IDLE;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset and only committed stores change them.
  always_ff @(posedge clk) begin
    if (store_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
